hqc_rsdecod_chien: RTL and testbench
====================================

Name: hqc_rsdecod_chien

Overview:
- Chien-search stage of RS decoding for HQC. It sits directly upstream of the error-value stage.
- Takes the error-locator polynomial sigma from the Berlekamp stage and evaluates it at alpha^(-i) for every codeword position i = 0..N1-1.
- Produces the per-position byte error map that the error-value stage consumes as its error input.
- Output byte is non-zero exactly at error locations.

Parameters:
- PARAM_SECURITY, 128, selects the parameter set (128/192/256).
- PARAM_DELTA, 15/16/29 by set, RS correction capacity; sigma degree is at most PARAM_DELTA.
- PARAM_N1, 46/56/90 by set, RS code length in bytes.
- SIGMA_W, 8*(PARAM_DELTA+1), sigma bus width.
- ERR_W, 8*PARAM_N1, error-map bus width.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- sigma_i  in  SIGMA_W  sigma = {s[DELTA],...,s[1],s[0]}, one byte per coefficient, s[0] in bits [7:0].
- start_i  in  1  start pulse; sigma_i is sampled on the same edge.
- busy_o  out  1  high while evaluating.
- error_o  out  ERR_W  error map {e[N1-1],...,e[0]}; e[i] = 8'h01 if position i is in error, else 8'h00.
- dout_valid_o  out  1  one-cycle pulse; error_o is valid from this cycle on.

Behaviour:
- Reset (asynchronous, active-high):
  - busy_o=0, dout_valid_o=0, error_o=0.
  - State=IDLE, position counter=0, all Chien registers=0.
- GF(2^8) arithmetic:
  - Primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D); alpha=2.
  - Addition is XOR.
- Chien registers r[0..DELTA] (8 bits each), one constant multiplier per register with constant c[k] = alpha^(255-k mod 255).
  - c[0]=1, so r[0] needs no multiplier.
- State machine IDLE -> EVAL -> DONE -> IDLE:
  - IDLE: on start_i, load r[k]=s[k], clear counter i, go to EVAL; busy_o=1 from the next cycle.
  - EVAL, each cycle:
    - v = XOR of all r[k], equal to sigma(alpha^(-i)).
    - Shift (v==0 ? 8'h01 : 8'h00) into the top of the error shift register; the register shifts right by 8, so after N1 shifts position 0 sits in bits [7:0].
    - r[k] <= r[k]*c[k]; i <= i+1.
    - When i==N1-1, go to DONE.
  - DONE: copy the shift register to error_o, pulse dout_valid_o for one cycle, deassert busy_o in the same cycle, return to IDLE.
- Latency: start sampled at edge T; EVAL occupies edges T+1..T+N1; dout_valid_o is high in the cycle after edge T+N1+1, i.e. N1+1 cycles after start.
- start_i while busy_o=1 is ignored; the run in progress is unaffected.
- error_o holds its last value until the next DONE. It does not change during a new EVAL because evaluation uses a separate shift register.
- sigma all-zero: every position is flagged (8'h01 ×N1). This is a defined, non-trapping result; the higher layer treats it as decoding failure.
- Reset asserted mid-EVAL:
  - Immediate return to IDLE with reset values.
  - No dout_valid_o pulse.
  - error_o cleared to 0.
- A position counter must not exceed N1-1; no wrap beyond N1 is allowed.

Optional Feature:
- Macro HQC_RSDECOD_CHIEN_ERRCNT_EN.
- When defined:
  - Extra output err_cnt_o [6:0], the number of flagged positions. It is counted during EVAL, reset to 0 on start, and valid with dout_valid_o.
  - Extra output fail_o [0:0], high with dout_valid_o when err_cnt_o differs from deg(sigma). deg(sigma) is computed combinationally at start as the highest index with non-zero s[k], and registered.
- When undefined: neither port exists, and the counter and degree logic are not instantiated.

Decomposition:
- Shared package hqc_rs_pkg holds:
  - GF_POLY=0x11D.
  - Per-security-level DELTA/N1 constants.
  - The gf_pow constant function used to derive c[k] at elaboration.
- One natural sub-module: gf_const_mul (parameter CONST [7:0]). It is a purely combinational multiply-by-constant XOR network, instantiated DELTA times.

Test Plan:
- Check 1 (no errors): sigma = {0...,0,8'h01}, start → after N1+1 cycles dout_valid_o=1 and error_o = all zero; busy_o is high for exactly N1 cycles.
- Check 2 (single error): sigma s[1]=8'h08 (alpha^3), s[0]=8'h01 → only byte 3 of error_o = 8'h01.
- Check 3 (two errors): sigma s[2]=8'h02, s[1]=8'h03, s[0]=8'h01, i.e. (1+x)(1+alpha x) → bytes 0 and 1 = 8'h01, all others 0; with the macro, err_cnt_o=2 and fail_o=0.
- Check 4 (degenerate and failure): sigma all zero → all N1 bytes = 8'h01. Separately, sigma s[2]=8'h01, s[0]=8'h01, i.e. 1+x^2=(1+x)^2 with a repeated root → only byte 0 is flagged; with the macro, err_cnt_o=1 and fail_o=1.
- Check 5 (protocol): a second start_i pulse at cycle T+5 during a run → ignored; single dout_valid_o at T+N1+1 with the first run's result.
- Check 6 (reset mid-run): assert rst_i at cycle T+10 for one cycle → busy_o=0, error_o=0, no dout_valid_o; a subsequent start with the Check 2 sigma yields the correct result.

Source files
------------

// File: rtl/hqc_rs_pkg.sv
// Shared RS/GF(2^8) definitions for the HQC decoder stages: field polynomial,
// per-security-level code parameters and elaboration-time GF helpers.
package hqc_rs_pkg;

    localparam logic [8:0] GF_POLY = 9'h11D;

    localparam int unsigned DELTA_128 = 15;
    localparam int unsigned N1_128    = 46;
    localparam int unsigned DELTA_192 = 16;
    localparam int unsigned N1_192    = 56;
    localparam int unsigned DELTA_256 = 29;
    localparam int unsigned N1_256    = 90;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } chien_state_e;

    function automatic int unsigned rs_delta(input int unsigned sec);
        case (sec)
            192:     return DELTA_192;
            256:     return DELTA_256;
            default: return DELTA_128;
        endcase
    endfunction

    function automatic int unsigned rs_n1(input int unsigned sec);
        case (sec)
            192:     return N1_192;
            256:     return N1_256;
            default: return N1_128;
        endcase
    endfunction

    // Multiply by alpha (x) modulo the field polynomial.
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY[7:0] : 8'h00);
    endfunction

    // alpha^e, used only at elaboration to derive multiplier constants.
    function automatic logic [7:0] gf_pow(input int unsigned e);
        logic [7:0] r;
        r = 8'h01;
        for (int unsigned j = 0; j < 255; j++) begin
            if (j < (e % 255)) begin
                r = gf_xtime(r);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gf_const_mul.sv
// Combinational GF(2^8) multiply-by-constant: an XOR network of shifted
// copies of CONST selected by the operand bits.
module gf_const_mul
    import hqc_rs_pkg::*;
#(
    parameter logic [7:0] CONST = 8'h01
) (
    input  logic [7:0] a_i,
    output logic [7:0] prod_o
);

    logic [7:0] term_c;

    always_comb begin
        prod_o = 8'h00;
        term_c = CONST;
        for (int b = 0; b < 8; b++) begin
            if (a_i[b]) begin
                prod_o = prod_o ^ term_c;
            end
            term_c = gf_xtime(term_c);
        end
    end

endmodule

// File: rtl/hqc_rsdecod_chien.sv
// Chien search for the HQC RS decoder: evaluates sigma at alpha^(-i) for every
// codeword position and emits a byte error map. Optional HQC_RSDECOD_CHIEN_ERRCNT_EN
// adds a flagged-position count and a degree-mismatch failure flag.
module hqc_rsdecod_chien
    import hqc_rs_pkg::*;
#(
    parameter int unsigned PARAM_SECURITY = 128,
    parameter int unsigned PARAM_DELTA    = rs_delta(PARAM_SECURITY),
    parameter int unsigned PARAM_N1       = rs_n1(PARAM_SECURITY),
    parameter int unsigned SIGMA_W        = 8 * (PARAM_DELTA + 1),
    parameter int unsigned ERR_W          = 8 * PARAM_N1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [SIGMA_W-1:0] sigma_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic [ERR_W-1:0]   error_o,
    output logic               dout_valid_o
`ifdef HQC_RSDECOD_CHIEN_ERRCNT_EN
    ,
    output logic [6:0]         err_cnt_o,
    output logic [0:0]         fail_o
`endif
);

    localparam int unsigned CNT_W = (PARAM_N1 > 1) ? $clog2(PARAM_N1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PARAM_N1 - 1);

    chien_state_e                 state_q;
    logic [CNT_W-1:0]             cnt_q;
    logic [PARAM_DELTA:0][7:0]    r_q;
    logic [PARAM_DELTA:0][7:0]    r_d;
    logic [ERR_W-1:0]             sh_q;
    logic [ERR_W-1:0]             sh_d;
    logic [ERR_W-1:0]             error_q;
    logic                         busy_q;
    logic                         dout_valid_q;
    logic [7:0]                   v_c;
    logic                         flag_c;

    // r[0] has constant 1; the others step by alpha^(-k) each evaluation cycle.
    assign r_d[0] = r_q[0];
    for (genvar k = 1; k <= PARAM_DELTA; k++) begin : g_mul
        gf_const_mul #(
            .CONST(gf_pow(255 - k))
        ) u_mul (
            .a_i   (r_q[k]),
            .prod_o(r_d[k])
        );
    end

    always_comb begin
        v_c = 8'h00;
        for (int k = 0; k <= PARAM_DELTA; k++) begin
            v_c = v_c ^ r_q[k];
        end
    end

    assign flag_c = (v_c == 8'h00);
    assign sh_d   = {7'b0, flag_c, sh_q[ERR_W-1:8]};

`ifdef HQC_RSDECOD_CHIEN_ERRCNT_EN
    logic [6:0] err_cnt_q;
    logic [6:0] deg_q;
    logic [6:0] deg_c;
    logic       fail_q;

    // Highest index with a non-zero coefficient; all-zero sigma reports 0.
    always_comb begin
        deg_c = 7'd0;
        for (int k = 0; k <= PARAM_DELTA; k++) begin
            if (sigma_i[8*k +: 8] != 8'h00) begin
                deg_c = 7'(k);
            end
        end
    end

    assign err_cnt_o = err_cnt_q;
    assign fail_o    = fail_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            r_q          <= '0;
            sh_q         <= '0;
            error_q      <= '0;
            busy_q       <= 1'b0;
            dout_valid_q <= 1'b0;
`ifdef HQC_RSDECOD_CHIEN_ERRCNT_EN
            err_cnt_q    <= '0;
            deg_q        <= '0;
            fail_q       <= 1'b0;
`endif
        end else begin
            dout_valid_q <= 1'b0;
`ifdef HQC_RSDECOD_CHIEN_ERRCNT_EN
            fail_q       <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        r_q     <= sigma_i;
                        cnt_q   <= '0;
                        state_q <= ST_EVAL;
`ifdef HQC_RSDECOD_CHIEN_ERRCNT_EN
                        err_cnt_q <= '0;
                        deg_q     <= deg_c;
`endif
                    end
                end
                ST_EVAL: begin
                    busy_q <= 1'b1;
                    sh_q   <= sh_d;
                    r_q    <= r_d;
`ifdef HQC_RSDECOD_CHIEN_ERRCNT_EN
                    err_cnt_q <= err_cnt_q + 7'(flag_c);
`endif
                    // Counter saturates at the last position; DONE follows.
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    error_q      <= sh_q;
                    dout_valid_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
`ifdef HQC_RSDECOD_CHIEN_ERRCNT_EN
                    fail_q       <= (err_cnt_q != deg_q);
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign error_o      = error_q;
    assign dout_valid_o = dout_valid_q;

endmodule

// File: tb/tb_hqc_rsdecod_chien.sv
// Scoreboard bench for hqc_rsdecod_chien (128-bit set): directed and random
// sigma polynomials checked against a Horner-evaluation reference model.
module tb_hqc_rsdecod_chien;

    localparam int unsigned N1    = 46;
    localparam int unsigned DELTA = 15;
    localparam int unsigned SW    = 8 * (DELTA + 1);
    localparam int unsigned EW    = 8 * N1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [SW-1:0] sigma_i;
    logic          start_i;
    logic          busy_o;
    logic [EW-1:0] error_o;
    logic          dout_valid_o;
`ifdef HQC_RSDECOD_CHIEN_ERRCNT_EN
    logic [6:0]    err_cnt_o;
    logic [0:0]    fail_o;
`endif

    hqc_rsdecod_chien #(
        .PARAM_SECURITY(128)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sigma_i     (sigma_i),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .error_o     (error_o),
        .dout_valid_o(dout_valid_o)
`ifdef HQC_RSDECOD_CHIEN_ERRCNT_EN
        ,
        .err_cnt_o   (err_cnt_o),
        .fail_o      (fail_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [EW-1:0] err;
        int            cnt;
        bit            fail;
    } exp_t;

    exp_t          exp_q[$];
    int            total = 0;
    int            bad   = 0;
    logic [EW-1:0] held;

    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference GF(2^8) arithmetic, field polynomial 0x11D.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int j = 0; j < 8; j++) begin
            if (b[j]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] apow(input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int j = 0; j < e; j++) r = gmul(r, 8'h02);
        return r;
    endfunction

    function automatic exp_t model(input logic [SW-1:0] s);
        exp_t       e;
        logic [7:0] x;
        logic [7:0] acc;
        int         deg;
        e.err = '0;
        e.cnt = 0;
        deg   = 0;
        for (int k = 0; k <= DELTA; k++) if (s[8*k +: 8] != 8'h00) deg = k;
        for (int i = 0; i < N1; i++) begin
            x   = apow((255 - i) % 255);
            acc = 8'h00;
            for (int k = DELTA; k >= 0; k--) acc = gmul(acc, x) ^ s[8*k +: 8];
            if (acc == 8'h00) begin
                e.err[8*i +: 8] = 8'h01;
                e.cnt++;
            end
        end
        e.fail = (e.cnt != deg);
        return e;
    endfunction

    // Product of (1 + alpha^j x) over the given root exponents.
    function automatic logic [SW-1:0] from_roots(input int n, input int unsigned seed);
        logic [7:0]    p [DELTA+1];
        logic [7:0]    a;
        logic [SW-1:0] s;
        for (int k = 0; k <= DELTA; k++) p[k] = 8'h00;
        p[0] = 8'h01;
        for (int r = 0; r < n; r++) begin
            a = apow(int'((seed + 37 * r) % 255));
            for (int k = DELTA; k >= 1; k--) p[k] = p[k] ^ gmul(a, p[k-1]);
        end
        for (int k = 0; k <= DELTA; k++) s[8*k +: 8] = p[k];
        return s;
    endfunction

    function automatic logic [SW-1:0] rand_sigma();
        logic [SW-1:0] s;
        for (int w = 0; w < SW / 32; w++) s[32*w +: 32] = $urandom;
        return s;
    endfunction

    // Monitor: pops expectations on each output pulse, checks hold otherwise.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i) begin
            held = '0;
        end else if (dout_valid_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid actual=1 required=0 t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("error_map", error_o, e.err);
`ifdef HQC_RSDECOD_CHIEN_ERRCNT_EN
                chk("err_cnt", EW'(err_cnt_o), EW'(e.cnt));
                chk("fail", EW'(fail_o), EW'(e.fail));
`endif
                held = e.err;
            end
        end else begin
            chk("error_hold", error_o, held);
        end
    end

    // mode 0: plain run; 1: extra start mid-run; 2: reset mid-run (no result).
    task automatic run(input logic [SW-1:0] s, input int mode);
        int lat;
        int busy_n;
        bit seen;
        @(negedge clk_i);
        sigma_i = s;
        start_i = 1'b1;
        if (mode != 2) exp_q.push_back(model(s));
        @(negedge clk_i);
        start_i = 1'b0;
        sigma_i = rand_sigma();
        busy_n  = 0;
        seen    = 1'b0;
        for (lat = 0; lat < 3 * N1; lat++) begin
            if (busy_o) busy_n++;
            if (dout_valid_o) begin
                seen = 1'b1;
                break;
            end
            start_i = (mode == 1 && lat == 5);
            if (mode == 2 && lat == 10) begin
                #2 rst_i = 1'b1;
                #1;
                chk("rst_busy", EW'(busy_o), '0);
                chk("rst_valid", EW'(dout_valid_o), '0);
                chk("rst_error", error_o, '0);
                break;
            end
            @(negedge clk_i);
        end
        start_i = 1'b0;
        if (mode == 2) begin
            @(negedge clk_i);
            #2 rst_i = 1'b0;
            repeat (N1 + 5) @(negedge clk_i);
        end else begin
            if (!seen) $display("FAIL timeout actual=no_valid required=valid t=%0t", $time);
            chk("latency", EW'(lat), EW'(N1 + 1));
            chk("busy_cycles", EW'(busy_n), EW'(N1));
        end
    endtask

    initial begin
        logic [SW-1:0] s2;
        logic [SW-1:0] s;
        rst_i   = 1'b1;
        start_i = 1'b0;
        sigma_i = '0;
        repeat (3) @(negedge clk_i);
        chk("reset_busy", EW'(busy_o), '0);
        chk("reset_valid", EW'(dout_valid_o), '0);
        chk("reset_error", error_o, '0);
        rst_i = 1'b0;

        s = '0; s[7:0] = 8'h01;
        run(s, 0);
        s2 = '0; s2[15:8] = 8'h08; s2[7:0] = 8'h01;
        run(s2, 0);
        s = '0; s[23:16] = 8'h02; s[15:8] = 8'h03; s[7:0] = 8'h01;
        run(s, 0);
        run('0, 0);
        s = '0; s[23:16] = 8'h01; s[7:0] = 8'h01;
        run(s, 0);
        s = '0; s[23:16] = 8'h02; s[15:8] = 8'h03; s[7:0] = 8'h01;
        run(s, 1);
        run(rand_sigma(), 2);
        run(s2, 0);

        for (int t = 0; t < 24; t++) begin
            if (t % 2 == 0) run(from_roots($urandom_range(0, DELTA), $urandom_range(0, 254)), 0);
            else            run(rand_sigma(), 0);
        end

        repeat (5) @(negedge clk_i);
        chk("pending_results", EW'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
